// File: rtl/mux8_rr_arbiter_if.sv
// Handshake/bus bundle between the eight requesters, the arbiter and the
// downstream consumer of the registered output word.
interface mux8_rr_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [7:0]         req;
  logic [7:0]         last;
  logic [8*WIDTH-1:0] din;
  logic [7:0]         ack;
  logic [2:0]         sel;
  logic               busy;
  logic [WIDTH-1:0]   dout;
  logic               dout_last;
  logic [2:0]         dout_src;
  logic               dout_valid;
  logic               dout_ready;
  logic               err;

  // Arbiter side
  modport slave (
    input  req, last, din, dout_ready,
    output ack, sel, busy, dout, dout_last, dout_src, dout_valid, err
  );

  // Requester / consumer side
  modport master (
    output req, last, din, dout_ready,
    input  ack, sel, busy, dout, dout_last, dout_src, dout_valid, err
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 8-to-1 word selector.
// A grant is held for a whole packet (until the last beat is captured) or
// until the granted requester stays idle for TIMEOUT cycles.
module mux8_rr_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst_n,
  mux8_rr_arbiter_if.slave  bus
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [2:0]    sel, sel_next;
  logic [2:0]    ptr, ptr_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          err, err_next;
  logic [2:0]    winner;
  logic          space;
  logic          capture;

  logic [WIDTH-1:0] dout;
  logic             dout_last;
  logic [2:0]       dout_src;
  logic             dout_valid;

  assign space   = !dout_valid || bus.dout_ready;
  assign capture = (state == BUSY) && bus.req[sel] && space;

  // First requesting index at or after the round-robin pointer
  always_comb begin
    logic       found;
    logic [2:0] idx;
    found  = 1'b0;
    idx    = '0;
    winner = ptr;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && bus.req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Grant FSM and round-robin/timeout state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= '0;
      ptr   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      sel   <= sel_next;
      ptr   <= ptr_next;
      cnt   <= cnt_next;
      err   <= err_next;
    end
  end

  // Next-state: arbitrate in IDLE, release on last beat or idle timeout in BUSY
  always_comb begin
    state_next = state;
    sel_next   = sel;
    ptr_next   = ptr;
    cnt_next   = cnt;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req != '0) begin
          sel_next   = winner;
          state_next = BUSY;
          cnt_next   = '0;
        end
      end
      BUSY: begin
        if (capture) begin
          cnt_next = '0;
          if (bus.last[sel]) begin
            state_next = IDLE;
            ptr_next   = sel + 3'd1;
          end
        end else if (!bus.req[sel] && space) begin
          // Backpressure (no space) deliberately freezes the counter
          if (TIMEOUT != 0 && cnt == LIMIT) begin
            state_next = IDLE;
            ptr_next   = sel + 3'd1;
            err_next   = 1'b1;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output register: capture the selected beat, or drain when consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_last  <= 1'b0;
      dout_src   <= '0;
      dout_valid <= 1'b0;
    end else if (capture) begin
      dout       <= bus.din[sel*WIDTH +: WIDTH];
      dout_last  <= bus.last[sel];
      dout_src   <= sel;
      dout_valid <= 1'b1;
    end else if (bus.dout_ready && dout_valid) begin
      dout_valid <= 1'b0;
    end
  end

  assign bus.ack        = capture ? (8'b1 << sel) : '0;
  assign bus.sel        = sel;
  assign bus.busy       = (state == BUSY);
  assign bus.dout       = dout;
  assign bus.dout_last  = dout_last;
  assign bus.dout_src   = dout_src;
  assign bus.dout_valid = dout_valid;
  assign bus.err        = err;
endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 8-to-1 32-bit word selector. Eight requesters compete for one registered output channel.
- Drives the 3-bit select (`sel`) and captures the selected word into an output register with valid/ready handshake.
- A requester keeps the grant for a multi-beat packet until its `last` beat is captured, or until an idle timeout aborts it.

Parameters:
- WIDTH, 32, data word width per requester.
- TIMEOUT, 16, consecutive granted-but-idle cycles before forced release; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  8  per-requester beat-available
- last  input  8  per-requester final-beat-of-packet flag, qualified by req
- din  input  8*WIDTH  requester words; requester i occupies din[i*WIDTH +: WIDTH]
- ack  output  8  one-hot, combinational; ack[i]=1 means requester i's beat is captured at the next edge
- sel  output  3  current grant index; drives the mux select
- busy  output  1  grant held (state BUSY)
- dout  output  WIDTH  registered output word
- dout_last  output  1  registered last flag accompanying dout
- dout_src  output  3  requester index of dout
- dout_valid  output  1  dout holds an unconsumed word
- dout_ready  input  1  downstream accepts dout this cycle
- err  output  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async, rst_n=0) clears: state=IDLE, sel=0, rr pointer ptr=0, dout=0, dout_last=0, dout_src=0, dout_valid=0, err=0, idle counter=0. busy=0 and ack=0 follow from state.
- space = !dout_valid || dout_ready.
- States: IDLE, BUSY. busy = (state==BUSY).
- IDLE
  - If req!=0, the winner is the first set bit of req scanning ptr, ptr+1, …, 7, 0, … (mod 8).
  - At the edge: sel<=winner, state<=BUSY, idle counter<=0.
  - ack=0 in IDLE; no beat is ever captured in the arbitration cycle.
- BUSY, capture
  - capture = req[sel] && space. Then ack[sel]=1 combinationally; all other ack bits 0.
  - At the edge: dout<=din[sel], dout_last<=last[sel], dout_src<=sel, dout_valid<=1, idle counter<=0.
  - If last[sel] was captured: state<=IDLE, ptr<=sel+1 (3-bit wrap, 7→0).
- BUSY, no capture
  - If !req[sel]: idle counter increments.
  - If !space: the counter holds; backpressure never triggers timeout.
- Drain: if dout_ready && dout_valid && !capture, then dout_valid<=0. dout, dout_last and dout_src keep their last values.
- Timeout
  - When TIMEOUT!=0 and the counter reaches TIMEOUT-1 while !req[sel] and space, at that edge: state<=IDLE, ptr<=sel+1, err<=1 for one cycle. No word is produced.
  - err is otherwise 0.
- Latency: req[i] rising in IDLE at cycle 0 → sel=i in cycle 1 with ack[i]=1 → dout_valid=1 in cycle 2. Back-to-back single-beat packets give one word every 2 cycles; in-packet beats stream at 1 word/cycle when dout_ready=1.
- Other requesters' req/last/din are ignored while BUSY. A new request arriving in the release cycle is not seen until IDLE.
- sel is stable for the whole grant and changes only on an IDLE→BUSY edge.
- Captured words bypass nothing: dout_valid and dout_src are purely registered.
- Reset asserted mid-packet aborts immediately to the reset values; the in-flight dout is lost. After release, arbitration restarts from requester 0.

Test Plan:
- Single beat: req=8'h08, last=8'h08, din3=32'hAA553333, dout_ready=1.
  - → cycle1: sel=3, ack=8'h08.
  - → cycle2: dout=32'hAA553333, dout_src=3, dout_last=1, dout_valid=1.
  - → cycle3: dout_valid=0.
- Round-robin fairness: all req=8'hFF, last=8'hFF, din_i=32'hAA55i i i i (i=0..7, e.g. 32'hAA551111), dout_ready=1.
  - → dout_src sequence 0,1,…,7,0.
  - → each ack bit pulses exactly once per 16 cycles.
- Packet lock: requester 1 sends 3 beats (last on the 3rd); req[2] is held throughout.
  - → ack[2]=0 until requester 1's last beat is captured.
  - → dout_src=1,1,1 then 2; ptr moves to 2.
- Backpressure: during a packet, dout_ready=0 for 5 cycles.
  - → dout frozen, ack=0, dout_valid=1, err=0.
  - → after dout_ready returns to 1, streaming resumes with no lost or duplicated word.
- Timeout: requester 5 sends one non-last beat then drops req; req[6]=1.
  - → err pulses 16 cycles after the beat's capture edge.
  - → state returns to IDLE; requester 6 is granted next (sel=6).
- Async reset: pull rst_n low mid-packet, between clock edges.
  - → dout_valid, busy, sel, dout clear immediately.
  - → after release, with req=8'hFF, the first grant is sel=0.
